flex_shift_array: RTL and testbench

- Parametrised 2-D packed-array serial shift register, generalising the fixed 3x5 shift chain.
- Configurable row/column count, base index, and range orientation.
- Adds bidirectional shift, rotate mode, parallel load, a fill counter, and a bounds-checked multi-bit tap.
- Sits beside other packed-array blocks as a reusable delay/deserialiser line and as a stress target for multi-dimensional flattening.

---
 rtl/flex_shift_array_if.sv | 46 ++++
 rtl/flex_shift_array.sv | 96 +++++++++
 tb/tb_flex_shift_array.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/flex_shift_array_if.sv
// Bundled control, data and status signals for flex_shift_array.
// The out vector's range orientation follows ROW_ASC/COL_ASC; element mapping does not.
interface flex_shift_array_if #(
  parameter int ROWS     = 3,
  parameter int COLS     = 5,
  parameter int ROW_BASE = 0,
  parameter int COL_BASE = 0,
  parameter int ROW_ASC  = 0,
  parameter int COL_ASC  = 0,
  parameter int TAP_W    = 2
);
  localparam int N      = ROWS * COLS;
  localparam int ROW_HI = ROW_BASE + ROWS - 1;
  localparam int COL_HI = COL_BASE + COLS - 1;
  localparam int ROW_L  = (ROW_ASC != 0) ? ROW_BASE : ROW_HI;
  localparam int ROW_R  = (ROW_ASC != 0) ? ROW_HI : ROW_BASE;
  localparam int COL_L  = (COL_ASC != 0) ? COL_BASE : COL_HI;
  localparam int COL_R  = (COL_ASC != 0) ? COL_HI : COL_BASE;
  localparam int TR_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TC_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W  = $clog2(N + 1);

  logic                          shift_en;
  logic                          dir;
  logic                          rotate;
  logic                          in_bit;
  logic                          load;
  logic [N-1:0]                  load_data;
  logic [TR_W-1:0]               tap_row;
  logic [TC_W-1:0]               tap_col;
  logic [ROW_L:ROW_R][COL_L:COL_R] out;
  logic                          serial_out;
  logic [TAP_W-1:0]              tap_out;
  logic [CNT_W-1:0]              fill_count;
  logic                          full;

  modport master (
    output shift_en, dir, rotate, in_bit, load, load_data, tap_row, tap_col,
    input  out, serial_out, tap_out, fill_count, full
  );

  modport slave (
    input  shift_en, dir, rotate, in_bit, load, load_data, tap_row, tap_col,
    output out, serial_out, tap_out, fill_count, full
  );
endinterface

// File: rtl/flex_shift_array.sv
// Parametrised 2-D serial shift register with bidirectional shift, rotate,
// parallel load, fill counter and a bounds-checked multi-bit tap.
module flex_shift_array #(
  parameter int ROWS     = 3,
  parameter int COLS     = 5,
  parameter int ROW_BASE = 0,
  parameter int COL_BASE = 0,
  parameter int ROW_ASC  = 0,
  parameter int COL_ASC  = 0,
  parameter int TAP_W    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  flex_shift_array_if.slave  bus
);
  localparam int N     = ROWS * COLS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Element k lives at bit k; the packed out view is pure wiring.
  logic [N-1:0]     elem_r;
  logic [N-1:0]     elem_next_s;
  logic [CNT_W-1:0] fill_r;
  logic [CNT_W-1:0] fill_next_s;
  logic             fwd_in_s;
  logic             rev_in_s;
  logic [TAP_W-1:0] tap_s;

  assign fwd_in_s = bus.rotate ? elem_r[N-1] : bus.in_bit;
  assign rev_in_s = bus.rotate ? elem_r[0]   : bus.in_bit;

  // Next contents: load beats shift beats hold.
  always_comb begin
    elem_next_s = elem_r;
    if (bus.load) begin
      elem_next_s = bus.load_data;
    end else if (bus.shift_en) begin
      if (!bus.dir) begin
        elem_next_s = (elem_r << 1'b1) | N'(fwd_in_s);
      end else begin
        elem_next_s = (elem_r >> 1'b1) | (N'(rev_in_s) << (N - 1));
      end
    end else begin
      elem_next_s = elem_r;
    end
  end

  // Fill count saturates at N; rotation recirculates, so it adds nothing.
  always_comb begin
    fill_next_s = fill_r;
    if (bus.load) begin
      fill_next_s = CNT_W'(N);
    end else if (bus.shift_en && !bus.rotate && (fill_r != CNT_W'(N))) begin
      fill_next_s = fill_r + CNT_W'(1);
    end else begin
      fill_next_s = fill_r;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      elem_r <= {N{1'b0}};
      fill_r <= {CNT_W{1'b0}};
    end else begin
      elem_r <= elem_next_s;
      fill_r <= fill_next_s;
    end
  end

  assign bus.serial_out = bus.dir ? elem_r[0] : elem_r[N-1];
  assign bus.fill_count = fill_r;
  assign bus.full       = (fill_r == CNT_W'(N));
  assign bus.tap_out    = tap_s;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign bus.out[ROW_BASE + r][COL_BASE + c] = elem_r[r * COLS + c];
    end
  end

  for (genvar j = 0; j < TAP_W; j++) begin : g_tap
    // Tap bit j reads zero once it falls off the row or past the last row.
    always_comb begin
      int row_i;
      int col_i;
      row_i = int'(bus.tap_row);
      col_i = int'(bus.tap_col) + j;
      if ((row_i < ROWS) && (col_i < COLS)) begin
        tap_s[j] = elem_r[IDX_W'(row_i * COLS + col_i)];
      end else begin
        tap_s[j] = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_flex_shift_array.sv
// Self-checking bench for flex_shift_array: vector table, corner-case
// sequences and random traffic against an array-based reference model.
module tb_flex_shift_array;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  flex_shift_array_if bus ();
  flex_shift_array_if #(.ROW_BASE(-1), .COL_BASE(-3), .ROW_ASC(1), .COL_ASC(0)) bus2 ();

  flex_shift_array dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  flex_shift_array #(.ROW_BASE(-1), .COL_BASE(-3), .ROW_ASC(1), .COL_ASC(0))
    dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit        ld;
    bit [14:0] ld_data;
    bit        sh;
    bit        dir;
    bit        rot;
    bit        inb;
    bit [1:0]  trow;
    bit [2:0]  tcol;
    bit [14:0] e_out;
    int        e_fill;
    bit        e_ser;
    bit [1:0]  e_tap;
  } vec_t;

  vec_t vt[12];

  // reference model state
  bit m[15];
  int mcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.load = 1'b0; bus.load_data = '0; bus.shift_en = 1'b0; bus.dir = 1'b0;
    bus.rotate = 1'b0; bus.in_bit = 1'b0; bus.tap_row = '0; bus.tap_col = '0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(bit ld, bit [14:0] ldd, bit sh, bit dir, bit rot, bit inb,
                              bit [1:0] tr, bit [2:0] tc, bit [14:0] eo, int ef,
                              bit es, bit [1:0] et);
    vec_t v;
    v.ld = ld; v.ld_data = ldd; v.sh = sh; v.dir = dir; v.rot = rot; v.inb = inb;
    v.trow = tr; v.tcol = tc; v.e_out = eo; v.e_fill = ef; v.e_ser = es; v.e_tap = et;
    return v;
  endfunction

  function automatic bit [14:0] model_pack();
    bit [14:0] v;
    for (int k = 0; k < 15; k++) v[k] = m[k];
    return v;
  endfunction

  task automatic model_step(input bit ld, input bit [14:0] ldd, input bit sh,
                            input bit dir, input bit rot, input bit inb);
    bit t;
    if (ld) begin
      for (int k = 0; k < 15; k++) m[k] = ldd[k];
      mcnt = 15;
    end else if (sh) begin
      if (!dir) begin
        t = rot ? m[14] : inb;
        for (int k = 14; k >= 1; k--) m[k] = m[k-1];
        m[0] = t;
      end else begin
        t = rot ? m[0] : inb;
        for (int k = 0; k <= 13; k++) m[k] = m[k+1];
        m[14] = t;
      end
      if (!rot && mcnt < 15) mcnt++;
    end
  endtask

  function automatic bit [1:0] model_tap(int row, int col);
    bit [1:0] t;
    for (int j = 0; j < 2; j++)
      t[j] = (row < 3 && col + j < 5) ? m[row * 5 + col + j] : 1'b0;
    return t;
  endfunction

  initial begin
    bit [14:0] flat;
    idle();
    bus2.load = 1'b0; bus2.load_data = '0; bus2.shift_en = 1'b0; bus2.dir = 1'b0;
    bus2.rotate = 1'b0; bus2.in_bit = 1'b0; bus2.tap_row = '0; bus2.tap_col = '0;

    vt[0]  = mk(0, 15'h0000, 1, 0, 0, 1, 2'd0, 3'd0, 15'h0001, 1,  0, 2'b01);
    vt[1]  = mk(0, 15'h0000, 1, 0, 0, 0, 2'd0, 3'd0, 15'h0002, 2,  0, 2'b10);
    vt[2]  = mk(0, 15'h0000, 1, 0, 0, 1, 2'd0, 3'd0, 15'h0005, 3,  0, 2'b01);
    vt[3]  = mk(1, 15'h4001, 1, 1, 1, 1, 2'd0, 3'd0, 15'h4001, 15, 1, 2'b01);
    vt[4]  = mk(0, 15'h0000, 1, 1, 1, 0, 2'd0, 3'd0, 15'h6000, 15, 0, 2'b00);
    vt[5]  = mk(1, 15'h1234, 0, 0, 0, 0, 2'd0, 3'd0, 15'h1234, 15, 0, 2'b00);
    vt[6]  = mk(0, 15'h0000, 1, 0, 1, 0, 2'd0, 3'd0, 15'h2468, 15, 0, 2'b00);
    vt[7]  = mk(1, 15'h7FFF, 0, 0, 0, 0, 2'd0, 3'd4, 15'h7FFF, 15, 1, 2'b01);
    vt[8]  = mk(0, 15'h0000, 0, 0, 0, 0, 2'd3, 3'd0, 15'h7FFF, 15, 1, 2'b00);
    vt[9]  = mk(0, 15'h0000, 0, 0, 0, 0, 2'd2, 3'd3, 15'h7FFF, 15, 1, 2'b11);
    vt[10] = mk(0, 15'h0000, 1, 0, 0, 0, 2'd1, 3'd0, 15'h7FFE, 15, 1, 2'b11);
    vt[11] = mk(0, 15'h0000, 1, 1, 0, 1, 2'd0, 3'd0, 15'h7FFF, 15, 1, 2'b11);

    // reset state, observed while reset is held
    #3;
    flat = bus.out;
    check("reset_out", 32'(flat), 32'h0);
    check("reset_fill", 32'(bus.fill_count), 32'd0);
    check("reset_full", 32'(bus.full), 32'd0);
    #9 reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.load = vt[i].ld; bus.load_data = vt[i].ld_data; bus.shift_en = vt[i].sh;
      bus.dir = vt[i].dir; bus.rotate = vt[i].rot; bus.in_bit = vt[i].inb;
      bus.tap_row = vt[i].trow; bus.tap_col = vt[i].tcol;
      tick();
      flat = bus.out;
      check($sformatf("vec%0d_out", i), 32'(flat), 32'(vt[i].e_out));
      check($sformatf("vec%0d_fill", i), 32'(bus.fill_count), 32'(vt[i].e_fill));
      check($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vt[i].e_fill == 15));
      check($sformatf("vec%0d_serial", i), 32'(bus.serial_out), 32'(vt[i].e_ser));
      check($sformatf("vec%0d_tap", i), 32'(bus.tap_out), 32'(vt[i].e_tap));
    end

    // fill from empty: 1,0,1 then 12 zeros, then one extra edge
    idle();
    pulse_reset();
    bus.shift_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.in_bit = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      tick();
    end
    flat = bus.out;
    check("fill15_out", 32'(flat), 32'h5000);
    check("fill15_serial", 32'(bus.serial_out), 32'd1);
    check("fill15_count", 32'(bus.fill_count), 32'd15);
    check("fill15_full", 32'(bus.full), 32'd1);
    tick();
    check("fill16_count", 32'(bus.fill_count), 32'd15);

    // full rotation returns the loaded pattern
    idle();
    bus.load = 1'b1; bus.load_data = 15'h1234;
    tick();
    bus.load = 1'b0; bus.shift_en = 1'b1; bus.rotate = 1'b1;
    tick();
    flat = bus.out;
    check("rot1_out", 32'(flat), 32'h2468);
    for (int i = 0; i < 14; i++) tick();
    flat = bus.out;
    check("rot15_out", 32'(flat), 32'h1234);
    check("rot15_fill", 32'(bus.fill_count), 32'd15);

    // asynchronous reset mid-sequence
    idle();
    pulse_reset();
    bus.shift_en = 1'b1; bus.in_bit = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    flat = bus.out;
    check("async_rst_out", 32'(flat), 32'h0);
    check("async_rst_fill", 32'(bus.fill_count), 32'd0);
    check("async_rst_full", 32'(bus.full), 32'd0);
    #1 reset_n = 1'b1;
    tick();
    flat = bus.out;
    check("post_rst_out", 32'(flat), 32'h0001);
    check("post_rst_fill", 32'(bus.fill_count), 32'd1);
    idle();

    // negative bases, ascending rows: element 5 sits at out[0][-3]
    bus2.shift_en = 1'b1; bus2.in_bit = 1'b1;
    tick();
    bus2.in_bit = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus2.shift_en = 1'b0; bus2.tap_row = 2'd1; bus2.tap_col = 3'd0;
    #1;
    check("neg_base_bit", 32'(bus2.out[0][-3]), 32'd1);
    check("neg_base_ones", 32'($countones(bus2.out)), 32'd1);
    check("neg_base_tap", 32'(bus2.tap_out), 32'h1);

    // random traffic against the reference model
    idle();
    pulse_reset();
    for (int k = 0; k < 15; k++) m[k] = 1'b0;
    mcnt = 0;
    for (int i = 0; i < 400; i++) begin
      bus.load      = ($urandom_range(0, 9) == 0);
      bus.load_data = 15'($urandom);
      bus.shift_en  = ($urandom_range(0, 2) != 0);
      bus.dir       = 1'($urandom);
      bus.rotate    = ($urandom_range(0, 3) == 0);
      bus.in_bit    = 1'($urandom);
      bus.tap_row   = 2'($urandom);
      bus.tap_col   = 3'($urandom);
      model_step(bus.load, bus.load_data, bus.shift_en, bus.dir, bus.rotate, bus.in_bit);
      tick();
      flat = bus.out;
      check("rnd_out", 32'(flat), 32'(model_pack()));
      check("rnd_fill", 32'(bus.fill_count), 32'(mcnt));
      check("rnd_full", 32'(bus.full), 32'(mcnt == 15));
      check("rnd_serial", 32'(bus.serial_out), 32'(bus.dir ? m[0] : m[14]));
      check("rnd_tap", 32'(bus.tap_out), 32'(model_tap(int'(bus.tap_row), int'(bus.tap_col))));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
